// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch predict unit.
// Holds the PC/index/tag geometry, the 2-bit BHT counter encoding with its
// saturating step functions, the BTB entry layout and the BHT write modes.
// TAG_W must stay >= 1, so PC_W has to exceed IDX_W+2.
package bpu_pkg;

    localparam int unsigned PC_W    = 9;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = PC_W - IDX_W - 2;
    localparam int unsigned NUM_ENT = 1 << IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_st_t;

    // How a BHT write derives the new counter value
    typedef enum logic [1:0] {
        BHT_TRAIN    = 2'b00,   // existing entry: step towards the outcome
        BHT_ALLOC    = 2'b01,   // fresh entry: WT if taken else WNT
        BHT_FORCE_ST = 2'b10    // unconditional jump: strongly taken
    } bht_wr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    function automatic bht_st_t sat_inc(input bht_st_t s);
        case (s)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic bht_st_t sat_dec(input bht_st_t s);
        case (s)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: 2**IDX_W two-bit saturating counters.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (all WNT)
//   rd_idx          fetch-side index
//   rd_state_c      combinational counter at rd_idx (old value on same-cycle write)
//   wr_en, wr_idx   resolve-side update strobe and index
//   wr_mode         train / allocate / force strongly-taken
//   wr_taken        resolved outcome of the instruction being written
module bpu_bht
    import bpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_st_t          rd_state_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bht_wr_t          wr_mode,
    input  logic             wr_taken
);

    bht_st_t tbl [NUM_ENT];
    bht_st_t wr_cur;
    bht_st_t wr_nxt;

    assign rd_state_c = tbl[rd_idx];

    // Next counter value for the entry being written
    always_comb begin
        wr_cur = tbl[wr_idx];
        wr_nxt = wr_cur;
        case (wr_mode)
            BHT_TRAIN:    wr_nxt = wr_taken ? sat_inc(wr_cur) : sat_dec(wr_cur);
            BHT_ALLOC:    wr_nxt = wr_taken ? WT : WNT;
            BHT_FORCE_ST: wr_nxt = ST;
            default:      wr_nxt = wr_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                tbl[i] <= WNT;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= wr_nxt;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB + 2-bit BHT prediction at IF,
// branch/jal/jalr resolution, mispredict redirect and table training at EX.
// Optional macro BPU_PERF_CNT_EN adds the perf_branches / perf_mispred
// counters; without it both ports are tied to zero and no counter flops exist.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_pc -> pred_taken/target  zero-cycle fetch prediction
//   ex_*                        instruction being resolved in EX
//   halt                        halt in EX: spin on ex_pc, no training
//   redirect, redirect_pc       flush request and corrected fetch PC
//   pc_four                     zero-extended ex_pc + 4 (link value)
//   perf_branches, perf_mispred performance counters
module branch_predict_unit
    import bpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    input  logic            halt,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     pc_four,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    btb_entry_t btb [NUM_ENT];

    // ---------------- fetch-side prediction ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    btb_entry_t       if_ent;
    bht_st_t          if_bht;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign if_ent = btb[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

    assign pred_taken  = if_hit && ((if_bht == WT) || (if_bht == ST));
    assign pred_target = pred_taken ? if_ent.target : (if_pc + PC_STEP);

    // ---------------- EX-side resolution ----------------
    logic             taken_c;
    logic [PC_W-1:0]  target_c;
    logic [PC_W-1:0]  fallthru_c;
    logic             mispred_c;
    logic             upd_c;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             btb_wr_c;
    bht_wr_t          bht_mode_c;

    assign taken_c    = (ex_branch & ex_alu_result[0]) | ex_jal | ex_jalr;
    assign target_c   = ex_jalr ? {ex_alu_result[PC_W-1:1], 1'b0}
                                : (ex_pc + ex_imm[PC_W-1:0]);
    assign fallthru_c = ex_pc + PC_STEP;
    assign mispred_c  = (taken_c != ex_pred_taken)
                      || (taken_c && (target_c != ex_pred_target));
    assign pc_four    = 32'(ex_pc) + 32'd4;

    // Upper operand bits only matter to the full-width datapath in EX
    logic unused_hi_bits;
    assign unused_hi_bits = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W]};

    // Redirect: halt spins on its own PC and outranks any mispredict
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = taken_c ? target_c : fallthru_c;
        if (!reset && ex_valid) begin
            if (halt) begin
                redirect    = 1'b1;
                redirect_pc = ex_pc;
            end else begin
                redirect    = mispred_c;
            end
        end
    end

    // ---------------- table training ----------------
    assign upd_c      = ex_valid & ~halt;
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_tag     = ex_pc[PC_W-1:IDX_W+2];
    assign ex_hit     = btb[ex_idx].valid && (btb[ex_idx].tag == ex_tag);
    // jalr targets are data dependent, so jalr never allocates
    assign btb_wr_c   = upd_c & ~ex_jalr & (ex_branch | ex_jal);
    assign bht_mode_c = ex_jal ? BHT_FORCE_ST : (ex_hit ? BHT_TRAIN : BHT_ALLOC);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                btb[i] <= '0;
            end
        end else if (btb_wr_c) begin
            btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: target_c};
        end
    end

    bpu_bht u_bht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (if_idx),
        .rd_state_c (if_bht),
        .wr_en      (btb_wr_c),
        .wr_idx     (ex_idx),
        .wr_mode    (bht_mode_c),
        .wr_taken   (taken_c)
    );

    // ---------------- performance counters ----------------
`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            if (upd_c && (ex_branch || ex_jal || ex_jalr)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (upd_c && mispred_c) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign perf_branches = br_cnt_q;
    assign perf_mispred  = mis_cnt_q;
`else
    assign perf_branches = 32'd0;
    assign perf_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: prediction, resolution,
// BHT saturation, jalr/wrap, halt, reset priority, aliasing and bubbles.
module tb_branch_predict_unit;

    logic        clk;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [8:0]  pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_jalr;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [8:0]  ex_pred_target;
    logic        halt;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic [31:0] pc_four;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;

    branch_predict_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_alu_result  (ex_alu_result),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .halt           (halt),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .pc_four        (pc_four),
        .perf_branches  (perf_branches),
        .perf_mispred   (perf_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       pt;
        logic [8:0] ptg;
        logic       rd;
        logic [8:0] rpc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          passed = 0;
    int          total  = 0;
    logic [31:0] m_br   = 0;
    logic [31:0] m_mis  = 0;

    function automatic logic [31:0] exp_br();
`ifdef BPU_PERF_CNT_EN
        return m_br;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_mis();
`ifdef BPU_PERF_CNT_EN
        return m_mis;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
        ex_alu_result = 0; ex_pred_taken = 0; ex_pred_target = 0; halt = 0;
    endtask

    task automatic drive(input logic [8:0] pc, input logic [31:0] imm, input logic br,
                         input logic jal, input logic jalr, input logic [31:0] alu,
                         input logic ptk, input logic [8:0] ptg, input logic hlt);
        ex_valid = 1; ex_pc = pc; ex_imm = imm; ex_branch = br; ex_jal = jal; ex_jalr = jalr;
        ex_alu_result = alu; ex_pred_taken = ptk; ex_pred_target = ptg; halt = hlt;
    endtask

    task automatic push(input string tag, input logic pt, input logic [8:0] ptg,
                        input logic rd, input logic [8:0] rpc);
        sb.push_back('{tag, pt, ptg, rd, rpc});
    endtask

    task automatic test_reset();
        reset = 1; idle(); if_pc = 9'h040;
        tick();
        drive(9'h100, 32'd8, 0, 1, 0, 0, 0, 9'h0, 0);
        push("reset_hold", 0, 9'h044, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick();
        reset = 0; idle(); if_pc = 9'h100;
        push("reset_jal_dropped", 0, 9'h104, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        if_pc = 9'h040;
        push("reset_if40", 0, 9'h044, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        total++;
        if (perf_branches !== 32'd0 || perf_mispred !== 32'd0)
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_branches, perf_mispred);
        else passed++;
    endtask

    task automatic test_branch_train();
        drive(9'h040, 32'h20, 1, 0, 0, 32'd1, 0, 9'h0, 0); if_pc = 9'h040;
        push("train_ex", 0, 9'h044, 1, 9'h060); m_br++; m_mis++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        total++;
        if (pc_four !== 32'h44) $display("FAIL pc_four: got %h want 00000044", pc_four);
        else passed++;
        tick(); idle();
        push("train_if", 1, 9'h060, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
    endtask

    // WT -> NT,NT,NT -> SNT; then T -> WNT (still not-taken), T -> WT
    task automatic test_bht_saturate();
        logic       alu [5] = '{0, 0, 0, 1, 1};
        logic       ptk [5] = '{1, 0, 0, 0, 0};
        logic [8:0] rpc [5] = '{9'h044, 9'h044, 9'h044, 9'h060, 9'h060};
        logic       rd  [5] = '{1, 0, 0, 1, 1};
        if_pc = 9'h040;
        for (int i = 0; i < 5; i++) begin
            drive(9'h040, 32'h20, 1, 0, 0, 32'(alu[i]), ptk[i], ptk[i] ? 9'h060 : 9'h0, 0);
            push($sformatf("sat_step%0d", i), ptk[i], ptk[i] ? 9'h060 : 9'h044, rd[i], rpc[i]);
            m_br++; if (rd[i]) m_mis++;
            #1;
            e = sb.pop_front(); total++;
            if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
                $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
            else passed++;
            tick();
        end
        idle();
        push("sat_final_wt", 1, 9'h060, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
    endtask

    task automatic test_jalr_wrap();
        drive(9'h040, 32'd0, 0, 0, 1, 32'h1F3, 0, 9'h0, 0); if_pc = 9'h040;
        push("jalr_ex", 1, 9'h060, 1, 9'h1F2); m_br++; m_mis++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); idle();
        push("jalr_no_alloc", 1, 9'h060, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        // Not-taken branch at the top of memory: fallthrough and IF+4 both wrap
        drive(9'h1FC, 32'h10, 1, 0, 0, 32'd0, 1, 9'h00C, 0); if_pc = 9'h1FC;
        push("wrap_fallthru", 0, 9'h000, 1, 9'h000); m_br++; m_mis++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick();
        // Correctly predicted jal whose target wraps: no redirect
        drive(9'h1F0, 32'h20, 0, 1, 0, 32'd0, 1, 9'h010, 0);
        push("jal_correct", 0, 9'h000, 0, 9'h0); m_br++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick();
        // Right direction, wrong target still redirects
        drive(9'h1F0, 32'h20, 0, 1, 0, 32'd0, 1, 9'h014, 0); if_pc = 9'h1F0;
        push("jal_bad_target", 1, 9'h010, 1, 9'h010); m_br++; m_mis++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); idle();
        total++;
        if (perf_branches !== exp_br() || perf_mispred !== exp_mis())
            $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", perf_branches, perf_mispred, exp_br(), exp_mis());
        else passed++;
    endtask

    task automatic test_halt_reset();
        drive(9'h088, 32'h10, 1, 0, 0, 32'd1, 0, 9'h0, 1); if_pc = 9'h088;
        push("halt_ex", 0, 9'h08C, 1, 9'h088); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); idle();
        push("halt_no_update", 0, 9'h08C, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        total++;
        if (perf_branches !== exp_br() || perf_mispred !== exp_mis())
            $display("FAIL halt_perf: got %0d/%0d want %0d/%0d", perf_branches, perf_mispred, exp_br(), exp_mis());
        else passed++;
        // Reset on the same edge as an update: reset wins, redirect held low
        reset = 1; drive(9'h100, 32'd8, 0, 1, 0, 32'd0, 0, 9'h0, 0); if_pc = 9'h040;
        push("reset_mid_hold", 1, 9'h060, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); reset = 0; idle(); m_br = 0; m_mis = 0;
        for (int i = 0; i < 3; i++) begin
            logic [8:0] pcs [3] = '{9'h040, 9'h1F0, 9'h100};
            if_pc = pcs[i];
            push($sformatf("reset_mid_inv%0d", i), 0, pcs[i] + 9'd4, 0, 9'h0); #1;
            e = sb.pop_front(); total++;
            if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
                $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
            else passed++;
        end
        total++;
        if (perf_branches !== 32'd0 || perf_mispred !== 32'd0)
            $display("FAIL reset_mid_perf: got %0d/%0d want 0/0", perf_branches, perf_mispred);
        else passed++;
    endtask

    task automatic test_alias();
        drive(9'h040, 32'h20, 0, 1, 0, 32'd0, 0, 9'h0, 0); if_pc = 9'h080;
        push("alias_train", 0, 9'h084, 1, 9'h060); m_br++; m_mis++; #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); idle(); if_pc = 9'h040;
        push("alias_owner_hit", 1, 9'h060, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        if_pc = 9'h080;
        push("alias_tag_miss", 0, 9'h084, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
    endtask

    task automatic test_bubble();
        drive(9'h088, 32'h10, 1, 0, 0, 32'd1, 0, 9'h0, 0); ex_valid = 0; if_pc = 9'h088;
        push("bubble_ex", 0, 9'h08C, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        tick(); idle();
        push("bubble_no_update", 0, 9'h08C, 0, 9'h0); #1;
        e = sb.pop_front(); total++;
        if (pred_taken !== e.pt || pred_target !== e.ptg || redirect !== e.rd || (e.rd && redirect_pc !== e.rpc))
            $display("FAIL %s: got pred %b/%h redir %b/%h, want %b/%h %b/%h", e.tag, pred_taken, pred_target, redirect, redirect_pc, e.pt, e.ptg, e.rd, e.rpc);
        else passed++;
        total++;
        if (perf_branches !== exp_br() || perf_mispred !== exp_mis())
            $display("FAIL bubble_perf: got %0d/%0d want %0d/%0d", perf_branches, perf_mispred, exp_br(), exp_mis());
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1; if_pc = 0; idle();
        test_reset();
        test_branch_train();
        test_bht_saturate();
        test_jalr_wrap();
        test_halt_reset();
        test_alias();
        test_bubble();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
